// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: compares the EX outcome with the fetch prediction, trains branch_hardware, issues flush/redirect.
// Latency: 1 cycle from consume to update/flush pulses and counter increments.
// Backpressure: ex_stall holds the instruction unconsumed; it is evaluated once, in the first unstalled cycle.
module branch_resolve_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic                  ex_stall,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_hit,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pred_target,
  output logic                  update_predictor,
  output logic                  update_btb,
  output logic                  actually_taken,
  output logic [DATA_WIDTH-1:0] resolved_pc,
  output logic [DATA_WIDTH-1:0] resolved_pc_target,
  output logic                  flush,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  logic [0:0]            state;
  logic                  consume;
  logic                  eff_taken;
  logic                  eff_pred;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  bc_sat;
  logic                  mc_sat;

  // A BTB miss means fetch fell through, so it counts as a not-taken prediction.
  assign consume    = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & (state == ST_RUN);
  assign eff_taken  = ex_is_jump | ex_taken;
  assign eff_pred   = ex_pred_hit & ex_pred_taken;
  assign mispredict = (eff_taken != eff_pred) |
                      (eff_taken & eff_pred & (ex_pred_target != ex_target));
  assign next_pc    = eff_taken ? ex_target : ex_pc + DATA_WIDTH'(4);
  assign bc_sat     = &branch_count;
  assign mc_sat     = &mispredict_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state              <= ST_RUN;
      update_predictor   <= 1'b0;
      update_btb         <= 1'b0;
      actually_taken     <= 1'b0;
      resolved_pc        <= '0;
      resolved_pc_target <= '0;
      flush              <= 1'b0;
      redirect_pc        <= '0;
      branch_count       <= '0;
      mispredict_count   <= '0;
    end else begin
      update_predictor <= consume & ex_is_branch;
      update_btb       <= consume & eff_taken;
      flush            <= consume & mispredict;

      // SQUASH covers exactly the flush cycle, while EX still holds the wrong-path instruction.
      if (state == ST_SQUASH)
        state <= ST_RUN;
      else if (consume && mispredict)
        state <= ST_SQUASH;

      if (consume) begin
        actually_taken     <= eff_taken;
        resolved_pc        <= ex_pc;
        resolved_pc_target <= ex_target;
        redirect_pc        <= next_pc;
        if (!bc_sat)
          branch_count <= branch_count + CNT_WIDTH'(1);
        if (mispredict && !mc_sat)
          mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with 2-bit counters so saturation is reachable.
module tb_branch_resolve_unit;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rstn;
  logic          ex_valid;
  logic          ex_is_branch;
  logic          ex_is_jump;
  logic          ex_stall;
  logic [DW-1:0] ex_pc;
  logic          ex_taken;
  logic [DW-1:0] ex_target;
  logic          ex_pred_hit;
  logic          ex_pred_taken;
  logic [DW-1:0] ex_pred_target;
  logic          update_predictor;
  logic          update_btb;
  logic          actually_taken;
  logic [DW-1:0] resolved_pc;
  logic [DW-1:0] resolved_pc_target;
  logic          flush;
  logic [DW-1:0] redirect_pc;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  int checks = 0;
  int passed = 0;

  branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .ex_valid           (ex_valid),
    .ex_is_branch       (ex_is_branch),
    .ex_is_jump         (ex_is_jump),
    .ex_stall           (ex_stall),
    .ex_pc              (ex_pc),
    .ex_taken           (ex_taken),
    .ex_target          (ex_target),
    .ex_pred_hit        (ex_pred_hit),
    .ex_pred_taken      (ex_pred_taken),
    .ex_pred_target     (ex_pred_target),
    .update_predictor   (update_predictor),
    .update_btb         (update_btb),
    .actually_taken     (actually_taken),
    .resolved_pc        (resolved_pc),
    .resolved_pc_target (resolved_pc_target),
    .flush              (flush),
    .redirect_pc        (redirect_pc),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic jp, input logic st,
                       input logic [DW-1:0] pc, input logic tk, input logic [DW-1:0] tg,
                       input logic hit, input logic pt, input logic [DW-1:0] ptg);
    ex_valid       = v;
    ex_is_branch   = br;
    ex_is_jump     = jp;
    ex_stall       = st;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_hit    = hit;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_pulses(input string tag, input logic up, input logic ub, input logic fl);
    chk({tag, ".upd_pred"}, DW'(update_predictor), DW'(up));
    chk({tag, ".upd_btb"},  DW'(update_btb),       DW'(ub));
    chk({tag, ".flush"},    DW'(flush),            DW'(fl));
  endtask

  task automatic chk_counts(input string tag, input int bc, input int mc);
    chk({tag, ".branch_count"},     DW'(branch_count),     DW'(bc));
    chk({tag, ".mispredict_count"}, DW'(mispredict_count), DW'(mc));
  endtask

  initial begin
    // Reset with random inputs
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom()), 1'($urandom()), 1'b0, 1'($urandom()), $urandom(), 1'($urandom()),
            $urandom(), 1'($urandom()), 1'($urandom()), $urandom());
      tick();
    end
    chk_pulses("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.actually_taken", DW'(actually_taken), '0);
    chk("reset.resolved_pc", resolved_pc, '0);
    chk("reset.resolved_pc_target", resolved_pc_target, '0);
    chk("reset.redirect_pc", redirect_pc, '0);
    chk_counts("reset", 0, 0);
    rstn = 1'b1;

    // Correctly predicted taken branch
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 1'b1, 32'h140);
    tick();
    chk_pulses("ok_taken", 1'b1, 1'b1, 1'b0);
    chk("ok_taken.actually_taken", DW'(actually_taken), 32'd1);
    chk("ok_taken.resolved_pc", resolved_pc, 32'h100);
    chk("ok_taken.resolved_pc_target", resolved_pc_target, 32'h140);
    chk_counts("ok_taken", 1, 0);

    // BTB miss on a taken branch
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
    tick();
    chk_pulses("miss_taken", 1'b1, 1'b1, 1'b1);
    chk("miss_taken.redirect_pc", redirect_pc, 32'h180);
    chk_counts("miss_taken", 2, 1);
    // Wrong-path branch in the squash cycle must be ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h900, 1'b1, 32'h990, 1'b0, 1'b0, 32'h0);
    tick();
    chk_pulses("squash_ignore", 1'b0, 1'b0, 1'b0);
    chk("squash_ignore.resolved_pc", resolved_pc, 32'h200);
    chk_counts("squash_ignore", 2, 1);

    // Predicted taken, actually not taken
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 32'h340, 1'b1, 1'b1, 32'h340);
    tick();
    chk_pulses("pt_nt", 1'b1, 1'b0, 1'b1);
    chk("pt_nt.redirect_pc", redirect_pc, 32'h304);
    chk("pt_nt.actually_taken", DW'(actually_taken), 32'd0);
    chk_counts("pt_nt", 3, 2);
    idle();
    tick();
    chk("pt_nt.flush_drop", DW'(flush), 32'd0);

    // Jump with BTB target mismatch; branch_count already saturated
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 1'b0, 32'h500, 1'b1, 1'b1, 32'h480);
    tick();
    chk_pulses("jal_tgt", 1'b0, 1'b1, 1'b1);
    chk("jal_tgt.redirect_pc", redirect_pc, 32'h500);
    chk_counts("jal_tgt", 3, 3);
    idle();
    tick();

    // Back-to-back correct predictions
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 1'b0, 32'h640, 1'b0, 1'b0, 32'h0);
    tick();
    chk_pulses("b2b_0", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h604, 1'b1, 32'h700, 1'b1, 1'b1, 32'h700);
    tick();
    chk_pulses("b2b_1", 1'b1, 1'b1, 1'b0);
    chk("b2b_1.resolved_pc", resolved_pc, 32'h604);

    // Fall-through redirect wraps at the top of the address space
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10);
    tick();
    chk("wrap.flush", DW'(flush), 32'd1);
    chk("wrap.redirect_pc", redirect_pc, 32'h0);
    idle();
    tick();

    // Stall for 3 cycles: exactly one update, after the stall drops
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 1'b1, 32'h720, 1'b1, 1'b1, 32'h720);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pulses("stall_hold", 1'b0, 1'b0, 1'b0);
    end
    ex_stall = 1'b0;
    tick();
    chk_pulses("stall_release", 1'b1, 1'b1, 1'b0);
    chk("stall_release.resolved_pc", resolved_pc, 32'h700);
    idle();
    tick();
    chk_pulses("stall_after", 1'b0, 1'b0, 1'b0);

    // Non-branch instruction is never consumed
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 1'b1, 32'h880, 1'b0, 1'b0, 32'h0);
    tick();
    chk_pulses("non_branch", 1'b0, 1'b0, 1'b0);

    // Reset during SQUASH drops flush and clears counters
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h800, 1'b1, 32'h880, 1'b0, 1'b0, 32'h0);
    tick();
    chk("pre_rst.flush", DW'(flush), 32'd1);
    rstn = 1'b0;
    tick();
    chk("rst_squash.flush", DW'(flush), 32'd0);
    chk("rst_squash.resolved_pc", resolved_pc, 32'h0);
    chk_counts("rst_squash", 0, 0);
    rstn = 1'b1;
    // Consume on the first cycle after reset shows state returned to RUN
    tick();
    chk_pulses("rst_run", 1'b1, 1'b1, 1'b1);
    idle();
    tick();

    // Saturation: five more mispredicts, counters stick at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, DW'(32'hA00 + 8 * i), 1'b1, 32'hB00, 1'b0, 1'b0, 32'h0);
      tick();
      idle();
      tick();
    end
    chk_counts("saturate", 3, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution block that sits directly upstream of `branch_hardware`. Each cycle it compares the actual outcome of the branch or jump in EX against the prediction that was carried down the pipe from fetch. It drives `branch_hardware`'s update interface and generates the front-end flush/redirect on a misprediction. It also keeps saturating branch and misprediction statistics counters for performance evaluation.

## Interface
- `DATA_WIDTH`, 32, PC/target width
- `CNT_WIDTH`, 32, width of statistics counters
- `clk`  input  1  clock; all state updates on the rising edge
- `rstn`  input  1  reset, synchronous, active-low
- `ex_valid`  input  1  EX holds a valid instruction
- `ex_is_branch`  input  1  conditional branch in EX
- `ex_is_jump`  input  1  unconditional jump (jal/jalr) in EX; mutually exclusive with `ex_is_branch`
- `ex_stall`  input  1  EX is stalled; instruction not consumed this cycle
- `ex_pc`  input  DATA_WIDTH  PC of the EX instruction
- `ex_taken`  input  1  actual branch outcome from the ALU (ignored for jumps)
- `ex_target`  input  DATA_WIDTH  computed taken-target address
- `ex_pred_hit`  input  1  BTB hit recorded at fetch
- `ex_pred_taken`  input  1  predictor direction recorded at fetch
- `ex_pred_target`  input  DATA_WIDTH  BTB target recorded at fetch
- `update_predictor`  output  1  pulse; train direction predictor
- `update_btb`  output  1  pulse; write BTB entry
- `actually_taken`  output  1  resolved direction
- `resolved_pc`  output  DATA_WIDTH  PC of resolved branch
- `resolved_pc_target`  output  DATA_WIDTH  resolved taken target
- `flush`  output  1  pulse; kill IF/ID/EX younger instructions
- `redirect_pc`  output  DATA_WIDTH  correct next PC, valid when `flush`=1
- `branch_count`  output  CNT_WIDTH  resolved branches+jumps
- `mispredict_count`  output  CNT_WIDTH  mispredictions

## Operation
- Consume condition: `consume = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & (state==RUN)`.
- Effective taken: `t = ex_is_jump | ex_taken`.
- Effective prediction: `p = ex_pred_hit & ex_pred_taken`. Fetch follows the target only on a BTB hit, so a miss counts as predicted not-taken.
- Mispredict: `m = (t != p) | (t & p & (ex_pred_target != ex_target))`.
- On consume, the registered outputs for the next cycle are:
  - `update_predictor = ex_is_branch`
  - `update_btb = t`
  - `actually_taken = t`
  - `resolved_pc = ex_pc`
  - `resolved_pc_target = ex_target`
  - `flush = m`
  - `redirect_pc = t ? ex_target : ex_pc + 4` (mod 2^DATA_WIDTH, wraps)
- Without consume, `update_predictor`, `update_btb` and `flush` are 0. The data outputs hold their last values.
- State machine:
  - RUN: entered from reset. Goes to SQUASH on consume with m=1.
  - SQUASH: lasts exactly one cycle, the cycle `flush` is high. EX then holds a wrong-path instruction, so all inputs are ignored (no consume, no counting) even if `ex_valid` is set. Always returns to RUN.
- Counters:
  - `branch_count` +1 per consume.
  - `mispredict_count` +1 per consume with m=1.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
  - Both update on the same edge as the output pulses.
- Stall: a stalled instruction is not consumed. It is evaluated once, in the first cycle `ex_stall`=0, so there is no double update. A stall arriving during SQUASH does not extend SQUASH.
- Non-branch instructions are never consumed.

## Timing
- Reset (`rstn`=0 at an edge): state=RUN; all outputs 0, including `resolved_pc`, `resolved_pc_target`, `redirect_pc` and the counters. Reset mid-SQUASH returns to RUN and drops `flush` on that edge.
- Latency is 1 cycle: an instruction consumed in cycle t drives its pulses and counter increments during cycle t+1.
- Pulses are 1 cycle wide. Back-to-back consumes in t and t+1 give pulses in t+1 and t+2, possible only while predictions are correct.
- `flush` and `redirect_pc` are asserted together for exactly one cycle. `branch_hardware` update and flush occur in the same cycle.
- After a flush in cycle t+1, the next consume is possible in cycle t+2 at the earliest.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles with random inputs -> all outputs 0, counters 0.
- Correct taken branch: pc=0x100, taken=1, target=0x140, hit=1, pred=1, pred_target=0x140 -> next cycle `update_predictor`=1, `update_btb`=1, `flush`=0, `branch_count`=1, `mispredict_count`=0.
- Miss, taken: pc=0x200, taken=1, target=0x180, hit=0 -> `flush`=1, `redirect_pc`=0x180; following cycle a valid branch in EX is ignored; `mispredict_count`=1.
- Predicted taken, not taken: pc=0x300, hit=1, pred=1, taken=0 -> `flush`=1, `redirect_pc`=0x304, `update_btb`=0, `update_predictor`=1.
- Jump with target mismatch: jal pc=0x400, target=0x500, pred_target=0x480, hit=1, pred=1 -> `flush`=1, `redirect_pc`=0x500, `update_predictor`=0, `update_btb`=1.
- Stall and saturation: branch held with `ex_stall`=1 for 3 cycles -> exactly one update pulse, after the stall drops. With CNT_WIDTH=2, after 5 mispredicts -> both counters stuck at 3.
